// File: rtl/cgia_bus_arbiter.sv
// Arbitrates the CGIA video-RAM slave port between the video fetcher and the host CPU.
// Video has priority; per-tenure ack limits keep either master from starving the other.
module cgia_bus_arbiter #(
  parameter int unsigned VID_BURST = 8,
  parameter int unsigned CPU_BURST = 1,
  parameter int unsigned CNT_W     = 4
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        vid_cyc_i,
  input  logic [22:0] vid_adr_i,
  output logic        vid_ack_o,
  output logic [15:0] vid_dat_o,
  input  logic        cpu_cyc_i,
  input  logic        cpu_stb_i,
  input  logic        cpu_we_i,
  input  logic [22:0] cpu_adr_i,
  input  logic [15:0] cpu_dat_i,
  input  logic [1:0]  cpu_sel_i,
  output logic        cpu_ack_o,
  output logic [15:0] cpu_dat_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [22:0] adr_o,
  output logic [15:0] dat_o,
  output logic [1:0]  sel_o,
  input  logic        ack_i,
  input  logic [15:0] dat_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    VID  = 2'b01,
    CPU  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] VID_LIM = (VID_BURST == 0) ? '0 : CNT_W'(VID_BURST - 1);
  localparam logic [CNT_W-1:0] CPU_LIM = (CPU_BURST == 0) ? '0 : CNT_W'(CPU_BURST - 1);
  localparam logic             VID_SAT = (VID_BURST == 0);
  localparam logic             CPU_SAT = (CPU_BURST == 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owed_q, owed_d;
  logic             vid_limit, cpu_limit;

  // Counter wraps when a limit is configured, saturates when unlimited.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic sat);
    return (sat && (c == CNT_MAX)) ? c : c + 1'b1;
  endfunction

  // Preemption only ever happens on the edge of an acked beat.
  assign vid_limit = !VID_SAT && cpu_cyc_i && ack_i && (cnt_q == VID_LIM);
  assign cpu_limit = !CPU_SAT && vid_cyc_i && ack_i && (cnt_q == CPU_LIM);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owed_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owed_q  <= owed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owed_d  = owed_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (owed_q && cpu_cyc_i) state_d = CPU;
        else if (vid_cyc_i)      state_d = VID;
        else if (cpu_cyc_i)      state_d = CPU;
      end
      VID: begin
        if (ack_i) cnt_d = bump(cnt_q, VID_SAT);
        if (!vid_cyc_i || vid_limit) state_d = IDLE;
        if (vid_limit) owed_d = 1'b1;
      end
      CPU: begin
        if (ack_i) cnt_d = bump(cnt_q, CPU_SAT);
        if (!cpu_cyc_i || cpu_limit) begin
          state_d = IDLE;
          owed_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slave port mux driven straight from the owner register.
  always_comb begin
    cyc_o = 1'b0;
    stb_o = 1'b0;
    we_o  = 1'b0;
    adr_o = '0;
    dat_o = '0;
    sel_o = '0;
    unique case (state_q)
      VID: begin
        cyc_o = vid_cyc_i;
        stb_o = vid_cyc_i;
        sel_o = 2'b11;
        adr_o = vid_adr_i;
      end
      CPU: begin
        cyc_o = cpu_cyc_i;
        stb_o = cpu_stb_i;
        we_o  = cpu_we_i;
        adr_o = cpu_adr_i;
        dat_o = cpu_dat_i;
        sel_o = cpu_sel_i;
      end
      default: ;
    endcase
  end

  assign vid_ack_o = ack_i && (state_q == VID);
  assign cpu_ack_o = ack_i && (state_q == CPU);
  assign vid_dat_o = dat_i;
  assign cpu_dat_o = dat_i;
  assign gnt_o     = 2'(state_q);

endmodule

// File: tb/tb_cgia_bus_arbiter.sv
// Directed and randomized bench for cgia_bus_arbiter against a tenure-level reference model.
module tb_cgia_bus_arbiter;

  localparam int unsigned VB = 8;
  localparam int unsigned CB = 1;
  localparam int unsigned CW = 4;
  localparam int CNT_MOD = 1 << CW;

  logic        clk, reset_ni;
  logic        vid_cyc, vid_ack;
  logic [22:0] vid_adr;
  logic [15:0] vid_rdat, cpu_rdat;
  logic        cpu_cyc, cpu_stb, cpu_we, cpu_ack;
  logic [22:0] cpu_adr;
  logic [15:0] cpu_wdat;
  logic [1:0]  cpu_sel;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [22:0] s_adr;
  logic [15:0] s_wdat, s_rdat;
  logic [1:0]  s_sel, gnt;

  int n_cmp = 0;
  int n_err = 0;
  int m_owner;   // 0 none, 1 video, 2 CPU
  int m_beats;   // acks received in the current tenure
  bit m_owed;
  int vid_acks, cpu_acks;
  bit last_vid_ack;
  logic [22:0] held;

  cgia_bus_arbiter #(.VID_BURST(VB), .CPU_BURST(CB), .CNT_W(CW)) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .vid_cyc_i(vid_cyc), .vid_adr_i(vid_adr), .vid_ack_o(vid_ack), .vid_dat_o(vid_rdat),
    .cpu_cyc_i(cpu_cyc), .cpu_stb_i(cpu_stb), .cpu_we_i(cpu_we), .cpu_adr_i(cpu_adr),
    .cpu_dat_i(cpu_wdat), .cpu_sel_i(cpu_sel), .cpu_ack_o(cpu_ack), .cpu_dat_o(cpu_rdat),
    .cyc_o(s_cyc), .stb_o(s_stb), .we_o(s_we), .adr_o(s_adr), .dat_o(s_wdat), .sel_o(s_sel),
    .ack_i(s_ack), .dat_i(s_rdat), .gnt_o(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A limit is reached when this ack is the BURST-th of the current window.
  function automatic bit at_limit(input int burst, input int beats);
    return (burst != 0) && ((beats % CNT_MOD) == burst - 1);
  endfunction

  task automatic model_reset();
    m_owner = 0;
    m_beats = 0;
    m_owed  = 1'b0;
  endtask

  task automatic model_step();
    bit lim;
    case (m_owner)
      0: begin
        m_beats = 0;
        if (m_owed && cpu_cyc) m_owner = 2;
        else if (vid_cyc)      m_owner = 1;
        else if (cpu_cyc)      m_owner = 2;
      end
      1: begin
        lim = cpu_cyc && s_ack && at_limit(VB, m_beats);
        if (s_ack) m_beats++;
        if (!vid_cyc || lim) m_owner = 0;
        if (lim) m_owed = 1'b1;
      end
      default: begin
        lim = vid_cyc && s_ack && at_limit(CB, m_beats);
        if (s_ack) m_beats++;
        if (!cpu_cyc || lim) begin
          m_owner = 0;
          m_owed  = 1'b0;
        end
      end
    endcase
  endtask

  task automatic check_outputs();
    logic [43:0] e_bus;
    logic [1:0]  e_gnt;
    case (m_owner)
      1:       begin e_bus = {vid_cyc, vid_cyc, 1'b0, 2'b11, vid_adr, 16'h0000}; e_gnt = 2'b01; end
      2:       begin e_bus = {cpu_cyc, cpu_stb, cpu_we, cpu_sel, cpu_adr, cpu_wdat}; e_gnt = 2'b10; end
      default: begin e_bus = '0; e_gnt = 2'b00; end
    endcase
    chk("gnt", 64'(gnt), 64'(e_gnt));
    chk("slave_bus", 64'({s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat}), 64'(e_bus));
    chk("acks", 64'({vid_ack, cpu_ack}), 64'({s_ack && m_owner == 1, s_ack && m_owner == 2}));
    chk("rdata", 64'({vid_rdat, cpu_rdat}), 64'({s_rdat, s_rdat}));
  endtask

  // One clock: check at negedge, advance model at posedge, return at posedge+1.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    last_vid_ack = vid_ack;
    if (vid_ack) vid_acks++;
    if (cpu_ack) cpu_acks++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic fetch_tick();
    tick();
    if (last_vid_ack) vid_adr = vid_adr + 23'd1;
  endtask

  initial begin
    reset_ni = 1'b0;
    vid_cyc = 0; vid_adr = '0;
    cpu_cyc = 0; cpu_stb = 0; cpu_we = 0; cpu_adr = '0; cpu_wdat = '0; cpu_sel = '0;
    s_ack = 0; s_rdat = 16'h1234;
    vid_acks = 0; cpu_acks = 0; last_vid_ack = 0;
    model_reset();
    #2;
    chk("rst_gnt", 64'(gnt), 64'(2'b00));
    chk("rst_bus", 64'({s_cyc, s_stb, s_we}), 64'(0));
    chk("rst_acks", 64'({vid_ack, cpu_ack}), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    reset_ni = 1'b1;

    // Video alone streams without limit when the CPU is idle
    vid_cyc = 1; s_ack = 1; vid_adr = 23'h000200;
    for (int i = 0; i < 12; i++) begin
      s_rdat = 16'($urandom);
      fetch_tick();
    end
    chk("vid_alone_acks", 64'(vid_acks), 64'(11));
    vid_cyc = 0; s_ack = 0;
    tick();

    // Video preempted after its 8th ack by a CPU write
    vid_acks = 0; cpu_acks = 0;
    vid_cyc = 1; s_ack = 1; vid_adr = 23'h001000;
    tick();
    for (int i = 0; i < 3; i++) fetch_tick();
    cpu_cyc = 1; cpu_stb = 1; cpu_we = 1; cpu_adr = 23'h000100; cpu_wdat = 16'hBEEF; cpu_sel = 2'b01;
    for (int i = 0; i < 5; i++) fetch_tick();
    held = vid_adr;
    chk("preempt_vid_acks", 64'(vid_acks), 64'(8));
    chk("preempt_gap", 64'({gnt, s_cyc}), 64'(3'b000));
    tick();
    chk("cpu_grant", 64'({gnt, s_we, s_sel, s_adr, s_wdat}), 64'({2'b10, 1'b1, 2'b01, 23'h000100, 16'hBEEF}));
    tick();
    chk("cpu_beats", 64'(cpu_acks), 64'(1));
    chk("cpu_release", 64'(gnt), 64'(2'b00));
    cpu_cyc = 0; cpu_stb = 0; cpu_we = 0;
    tick();
    chk("vid_regrant", 64'({gnt, s_adr}), 64'({2'b01, held}));
    fetch_tick();
    chk("vid_resume_acks", 64'(vid_acks), 64'(9));

    // Simultaneous requests from IDLE; video drops on its limit ack
    vid_cyc = 0; s_ack = 0;
    tick(); tick();
    vid_acks = 0; cpu_acks = 0;
    vid_cyc = 1; cpu_cyc = 1; cpu_stb = 1; s_ack = 1;
    tick();
    chk("both_idle_acks", 64'({vid_acks, cpu_acks}), 64'(0));
    chk("both_vid_wins", 64'(gnt), 64'(2'b01));
    for (int i = 0; i < 7; i++) fetch_tick();
    vid_cyc = 0;
    tick();
    chk("drop_limit_acks", 64'(vid_acks), 64'(8));
    s_ack = 0;
    tick();
    chk("drop_then_cpu", 64'({gnt, 6'(vid_acks)}), 64'({2'b10, 6'd8}));
    cpu_cyc = 0; cpu_stb = 0;
    tick();

    // Asynchronous reset in the middle of a CPU write
    cpu_cyc = 1; cpu_stb = 1; cpu_we = 1; cpu_adr = 23'h0000AA; cpu_wdat = 16'h5A5A; cpu_sel = 2'b11;
    tick();
    s_ack = 1;
    #2;
    reset_ni = 1'b0;
    #1;
    model_reset();
    chk("arst_bus", 64'({s_cyc, s_stb, cpu_ack}), 64'(0));
    chk("arst_gnt", 64'(gnt), 64'(2'b00));
    @(posedge clk); #1;
    reset_ni = 1'b1; s_ack = 0;
    tick();
    chk("arst_restart", 64'(gnt), 64'(2'b10));

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(7) == 0) vid_cyc = ~vid_cyc;
      if ($urandom_range(5) == 0) cpu_cyc = ~cpu_cyc;
      cpu_stb  = cpu_cyc & 1'($urandom);
      cpu_we   = 1'($urandom);
      cpu_adr  = 23'($urandom);
      cpu_wdat = 16'($urandom);
      cpu_sel  = 2'($urandom);
      s_ack    = ($urandom_range(3) != 0);
      s_rdat   = 16'($urandom);
      fetch_tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
